// File: rtl/mdio_arbiter_if.sv
// Requester and station-management-engine signals shared by mdio_arbiter and its users.
// The slave modport is the arbiter's view; master is the view of requesters plus engine.
interface mdio_arbiter_if;
  logic [3:0]  req;
  logic [3:0]  req_mode;
  logic [19:0] req_phy_address;
  logic [19:0] req_reg_address;
  logic [63:0] req_data_in;
  logic [3:0]  ack;
  logic [15:0] rsp_data;
  logic        busy;
  logic        begin_transaction;
  logic        mode;
  logic [4:0]  phy_address;
  logic [4:0]  reg_address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        link_up;

  modport slave (
    input  req, req_mode, req_phy_address, req_reg_address, req_data_in, data_out,
    output ack, rsp_data, busy, begin_transaction, mode, phy_address, reg_address,
           data_in, link_up
  );

  modport master (
    output req, req_mode, req_phy_address, req_reg_address, req_data_in, data_out,
    input  ack, rsp_data, busy, begin_transaction, mode, phy_address, reg_address,
           data_in, link_up
  );
endinterface

// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO station management engine among four requesters.
// Optional periodic PHY link poll is built when MDIO_LINK_POLL_EN is defined.
//
// state | meaning
// IDLE  | arbitrate; grant a requester (or a pending link poll when req==0)
// START | one-cycle begin_transaction pulse to the engine
// WAIT  | count down TXN_CYCLES-1 .. 0 while the engine runs
// DONE  | ack pulse / rsp_data or link_up update; last_grant advances
module mdio_arbiter #(
  parameter int         TXN_CYCLES    = 66,
  parameter int         POLL_INTERVAL = 65536,
  parameter logic [4:0] POLL_PHY      = 5'd0
) (
  input logic           clock,
  input logic           reset,
  mdio_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  localparam int CNT_W = $clog2(TXN_CYCLES + 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       grant;
  logic [1:0]       last_grant;
  logic             arb_found;
  logic [1:0]       arb_idx;

`ifdef MDIO_LINK_POLL_EN
  localparam int POLL_W = $clog2(POLL_INTERVAL + 1);

  logic [POLL_W-1:0] poll_cnt;
  logic              poll_sel;
  logic              poll_pending;

  assign poll_pending = (poll_cnt == '0);
`else
  assign bus.link_up = 1'b0;
`endif

  // Search from last_grant+1 upward; the 2-bit wrap makes last_grant itself the lowest rank.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_grant;
    for (int k = 1; k <= 4; k++) begin
      if (!arb_found && bus.req[last_grant + 2'(k)]) begin
        arb_found = 1'b1;
        arb_idx   = last_grant + 2'(k);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                 <= S_IDLE;
      wait_cnt              <= '0;
      grant                 <= 2'd0;
      last_grant            <= 2'd3;
      bus.ack               <= 4'b0000;
      bus.rsp_data          <= 16'h0000;
      bus.busy              <= 1'b0;
      bus.begin_transaction <= 1'b0;
      bus.mode              <= 1'b0;
      bus.phy_address       <= 5'd0;
      bus.reg_address       <= 5'd0;
      bus.data_in           <= 16'h0000;
`ifdef MDIO_LINK_POLL_EN
      poll_sel              <= 1'b0;
`endif
    end else begin
      bus.ack               <= 4'b0000;
      bus.begin_transaction <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_found) begin
            state                 <= S_START;
            grant                 <= arb_idx;
            bus.mode              <= bus.req_mode[arb_idx];
            bus.phy_address       <= bus.req_phy_address[5*arb_idx +: 5];
            bus.reg_address       <= bus.req_reg_address[5*arb_idx +: 5];
            bus.data_in           <= bus.req_data_in[16*arb_idx +: 16];
            bus.begin_transaction <= 1'b1;
            bus.busy              <= 1'b1;
`ifdef MDIO_LINK_POLL_EN
            poll_sel              <= 1'b0;
`endif
          end
`ifdef MDIO_LINK_POLL_EN
          else if (poll_pending) begin
            state                 <= S_START;
            bus.mode              <= 1'b0;
            bus.phy_address       <= POLL_PHY;
            bus.reg_address       <= 5'd1;
            bus.data_in           <= 16'h0000;
            bus.begin_transaction <= 1'b1;
            bus.busy              <= 1'b1;
            poll_sel              <= 1'b1;
          end
`endif
        end
        S_START: begin
          state    <= S_WAIT;
          wait_cnt <= CNT_W'(TXN_CYCLES - 1);
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_DONE;
`ifdef MDIO_LINK_POLL_EN
            if (!poll_sel) begin
              bus.ack <= 4'b0001 << grant;
              if (!bus.mode) bus.rsp_data <= bus.data_out;
            end
`else
            bus.ack <= 4'b0001 << grant;
            if (!bus.mode) bus.rsp_data <= bus.data_out;
`endif
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
`ifdef MDIO_LINK_POLL_EN
          if (!poll_sel) last_grant <= grant;
`else
          last_grant <= grant;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MDIO_LINK_POLL_EN
  // Timer saturates at zero so a poll stays pending until IDLE sees req==0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      poll_cnt    <= POLL_W'(POLL_INTERVAL - 1);
      bus.link_up <= 1'b0;
    end else begin
      if (state == S_DONE && poll_sel)
        poll_cnt <= POLL_W'(POLL_INTERVAL - 1);
      else if (poll_cnt != '0)
        poll_cnt <= poll_cnt - 1'b1;
      if (state == S_WAIT && wait_cnt == '0 && poll_sel)
        bus.link_up <= bus.data_out[2];
    end
  end
`endif

endmodule

// File: tb/tb_mdio_arbiter.sv
// Self-checking bench for mdio_arbiter: vector table of single transactions plus
// hand-written round-robin, cancellation, mid-transaction reset and link-poll sequences.
module tb_mdio_arbiter;
  localparam int TXN = 66;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mdio_arbiter_if bus ();
  mdio_arbiter #(.TXN_CYCLES(TXN)) dut (.clock(clock), .reset(reset), .bus(bus));

`ifdef MDIO_LINK_POLL_EN
  mdio_arbiter_if pbus ();
  mdio_arbiter #(.TXN_CYCLES(TXN), .POLL_INTERVAL(100), .POLL_PHY(5'd7)) pdut (
    .clock(clock), .reset(reset), .bus(pbus)
  );
  int   poll_begins = 0;
  int   poll_bad    = 0;
  int   poll_acks   = 0;
  logic first_link  = 1'b1;
  always @(negedge clock) begin
    if (reset) begin
      if (pbus.begin_transaction) begin
        if (poll_begins == 0) first_link = pbus.link_up;
        poll_begins++;
        if ({pbus.mode, pbus.phy_address, pbus.reg_address} !== {1'b0, 5'd7, 5'd1}) poll_bad++;
      end
      if (pbus.ack !== 4'b0000) poll_acks++;
    end
  end
`endif

  typedef struct {
    int          idx;
    logic        mode;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wdata;
    logic [15:0] eng;
  } vec_t;

  typedef struct {
    logic [3:0]  ack;
    logic [15:0] rsp;
    int          cyc;
    logic        mode;
    logic [15:0] din;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ack1_count = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] model_rsp;
  vec_t        vecs[6];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack is matched against the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.ack[1] === 1'b1) ack1_count++;
    if (bus.ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("stray_ack", {28'd0, bus.ack}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_vec", {28'd0, bus.ack}, {28'd0, mon_e.ack});
        chk("ack_cycle", cyc, mon_e.cyc);
        chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, mon_e.rsp});
        chk("mode_at_ack", {31'd0, bus.mode}, {31'd0, mon_e.mode});
        chk("data_in_at_ack", {16'd0, bus.data_in}, {16'd0, mon_e.din});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {24'd0, bus.ack, bus.busy, bus.begin_transaction, bus.mode, bus.link_up}, 32'd0);
    chk({tag, "_addr"}, {22'd0, bus.phy_address, bus.reg_address}, 32'd0);
    chk({tag, "_data"}, {bus.data_in, bus.rsp_data}, 32'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && bus.busy !== 1'b0; i++) @(negedge clock);
    if (bus.busy !== 1'b0) chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic start_txn(input vec_t v, output int c0);
    logic [3:0]  a;
    logic [15:0] r;
    wait_idle();
    @(posedge clock);
    #1;
    bus.req_mode[v.idx]                = v.mode;
    bus.req_phy_address[5*v.idx +: 5]  = v.phy;
    bus.req_reg_address[5*v.idx +: 5]  = v.rg;
    bus.req_data_in[16*v.idx +: 16]    = v.wdata;
    bus.data_out                       = v.eng;
    bus.req[v.idx]                     = 1'b1;
    c0 = cyc;
    a = 4'b0001 << v.idx;
    r = v.mode ? model_rsp : v.eng;
    model_rsp = r;
    sb.push_back('{ack: a, rsp: r, cyc: c0 + TXN + 2, mode: v.mode, din: v.wdata});
    @(negedge clock);
    chk("begin_c0", {31'd0, bus.begin_transaction}, 32'd0);
    @(negedge clock);
    chk("begin_c1", {31'd0, bus.begin_transaction}, 32'd1);
    chk("busy_c1", {31'd0, bus.busy}, 32'd1);
    chk("fields_c1", {5'd0, bus.mode, bus.phy_address, bus.reg_address, bus.data_in},
        {5'd0, v.mode, v.phy, v.rg, v.wdata});
    @(negedge clock);
    chk("begin_c2", {31'd0, bus.begin_transaction}, 32'd0);
  endtask

  task automatic finish_txn();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      chk("ack_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    #1;
    bus.req = 4'b0000;
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.req = 4'b0000;
    model_rsp = 16'h0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    int   a1;
    logic saw_busy;
    vec_t v;

    vecs[0] = '{idx: 0, mode: 1'b0, phy: 5'd3,  rg: 5'd2,  wdata: 16'h0000, eng: 16'hBEEF};
    vecs[1] = '{idx: 2, mode: 1'b1, phy: 5'd6,  rg: 5'd4,  wdata: 16'h1234, eng: 16'h5555};
    vecs[2] = '{idx: 1, mode: 1'b0, phy: 5'd31, rg: 5'd31, wdata: 16'h0000, eng: 16'h0000};
    vecs[3] = '{idx: 3, mode: 1'b1, phy: 5'd17, rg: 5'd8,  wdata: 16'hFFFF, eng: 16'hAAAA};
    vecs[4] = '{idx: 3, mode: 1'b0, phy: 5'd0,  rg: 5'd0,  wdata: 16'h0000, eng: 16'hA5A5};
    vecs[5] = '{idx: 0, mode: 1'b1, phy: 5'd12, rg: 5'd30, wdata: 16'h8001, eng: 16'h3C3C};

    bus.req = '0; bus.req_mode = '0; bus.req_phy_address = '0; bus.req_reg_address = '0;
    bus.req_data_in = '0; bus.data_out = '0;
`ifdef MDIO_LINK_POLL_EN
    pbus.req = '0; pbus.req_mode = '0; pbus.req_phy_address = '0; pbus.req_reg_address = '0;
    pbus.req_data_in = '0; pbus.data_out = 16'h0004;
`endif
    model_rsp = 16'h0000;
    #1;
    check_reset_outputs("reset_init");
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      start_txn(vecs[i], c0);
      finish_txn();
    end

    // Cancellation: req[1] pulses for one cycle while requester 0 is in WAIT.
    a1 = ack1_count;
    v = '{idx: 0, mode: 1'b0, phy: 5'd4, rg: 5'd9, wdata: 16'h0000, eng: 16'h7777};
    start_txn(v, c0);
    repeat (8) @(posedge clock);
    #1;
    bus.req_mode[1] = 1'b0;
    bus.req[1] = 1'b1;
    @(posedge clock);
    #1;
    bus.req[1] = 1'b0;
    finish_txn();
    saw_busy = 1'b0;
    repeat (100) begin
      @(negedge clock);
      if (bus.busy !== 1'b0) saw_busy = 1'b1;
    end
    chk("cancel_no_grant", {31'd0, saw_busy}, 32'd0);
    chk("cancel_no_ack1", ack1_count - a1, 32'd0);

    // Reset 30 cycles into a transaction abandons it without ack.
    wait_idle();
    @(posedge clock);
    #1;
    bus.req_mode[1] = 1'b0;
    bus.data_out = 16'h1111;
    bus.req[1] = 1'b1;
    c0 = cyc;
    while (cyc < c0 + 30) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    bus.req = 4'b0000;
    model_rsp = 16'h0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (100) @(negedge clock);
    chk("reset_mid_no_ack", sb.size(), 32'd0);
    v = '{idx: 2, mode: 1'b0, phy: 5'd9, rg: 5'd1, wdata: 16'h0000, eng: 16'h2222};
    start_txn(v, c0);
    finish_txn();

    // Round robin with all four requesting continuously from a fresh reset.
    pulse_reset();
    @(posedge clock);
    #1;
    bus.req_mode = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      bus.req_phy_address[5*i +: 5] = 5'(i + 1);
      bus.req_reg_address[5*i +: 5] = 5'(i + 10);
      bus.req_data_in[16*i +: 16]   = 16'(16'h0100 * (i + 1));
    end
    bus.data_out = 16'hC0DE;
    bus.req = 4'b1111;
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{ack: 4'(4'b0001 << (k % 4)), rsp: 16'hC0DE, cyc: c0 + TXN + 2 + 69*k,
                     mode: 1'b0, din: 16'(16'h0100 * ((k % 4) + 1))});
    end
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clock);
    #1;
    bus.req = 4'b0000;
    chk("rr_all_acked", sb.size(), 32'd0);
    sb.delete();
    repeat (5) @(negedge clock);

`ifdef MDIO_LINK_POLL_EN
    for (int i = 0; i < 300 && pbus.busy !== 1'b0; i++) @(negedge clock);
    chk("poll_seen", {31'd0, poll_begins != 0}, 32'd1);
    chk("poll_link_before", {31'd0, first_link}, 32'd0);
    chk("poll_fields", poll_bad, 32'd0);
    chk("poll_no_ack", poll_acks, 32'd0);
    chk("poll_link_up", {31'd0, pbus.link_up}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
